// File: rtl/uart_tx_scheduler_if.sv
`default_nettype none
// uart_tx_scheduler_if: requester-side bus of the shared UART transmitter.
// rev 1.0
interface uart_tx_scheduler_if;
  logic        en;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        tx;
  logic        busy;
  logic [1:0]  grant_id;
  logic        frame_done;

  modport master (
    output en, req_valid, req_data,
    input  req_ready, tx, busy, grant_id, frame_done
  );

  modport slave (
    input  en, req_valid, req_data,
    output req_ready, tx, busy, grant_id, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// uart_tx_scheduler: round-robin arbiter feeding one 8N1 UART transmitter.
// rev 1.0
module uart_tx_scheduler #(
  parameter int CLKS_PER_BIT = 430,
  parameter int NUM_REQ      = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_scheduler_if.slave bus
);

  localparam int               CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       bit_idx_q;
  logic             stop_cnt_q;
  logic [7:0]       shreg_q;
  logic [1:0]       ptr_q;
  logic             tx_q;
  logic             busy_q;
  logic [1:0]       grant_q;
  logic [3:0]       ready_q;
  logic             done_q;

  logic [1:0]       win_d;
  logic             any_d;
  logic             bit_end;

  // Scan downward so the requester closest to the pointer is the last to claim win_d.
  always_comb begin
    win_d = ptr_q;
    any_d = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[ptr_q + 2'(k)]) begin
        win_d = ptr_q + 2'(k);
        any_d = 1'b1;
      end
    end
  end

  assign bit_end = (cnt_q == CNT_LAST);
  assign cnt_d   = bit_end ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      shreg_q    <= 8'h00;
      ptr_q      <= 2'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      grant_q    <= 2'd0;
      ready_q    <= 4'b0000;
      done_q     <= 1'b0;
    end else begin
      ready_q <= 4'b0000;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (bus.en && any_d) begin
            shreg_q <= bus.req_data[{win_d, 3'b000} +: 8];
            grant_q <= win_d;
            ready_q <= 4'b0001 << win_d;
            ptr_q   <= win_d + 2'd1;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            tx_q      <= shreg_q[0];
            bit_idx_q <= 3'd0;
            state_q   <= DATA;
          end
        end
        DATA: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            if (bit_idx_q != 3'd7) begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shreg_q[bit_idx_q + 3'd1];
            end else begin
              tx_q       <= 1'b1;
              stop_cnt_q <= 1'b0;
              state_q    <= STOP;
            end
          end
        end
        STOP: begin
          cnt_q <= cnt_d;
          if (bit_end) begin
            if (stop_cnt_q == STOP_LAST) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.grant_id   = grant_q;
  assign bus.frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// tb_uart_tx_scheduler: directed bench for the shared UART transmitter.
// rev 1.0
module tb_uart_tx_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_scheduler_if bus_a ();
  uart_tx_scheduler_if bus_b ();

  uart_tx_scheduler #(.CLKS_PER_BIT(8), .NUM_REQ(4), .STOP_BITS(1)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  uart_tx_scheduler #(.CLKS_PER_BIT(4), .NUM_REQ(4), .STOP_BITS(2)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready_a(output bit found);
    found = 1'b0;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (bus_a.req_ready !== 4'b0000) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done_a(output bit found, output int n_cyc);
    found = 1'b0;
    n_cyc = 0;
    for (int n = 0; n < 300; n++) begin
      tick();
      n_cyc++;
      if (bus_a.frame_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus_a.en = 1'b0; bus_a.req_valid = 4'b0000; bus_a.req_data = 32'h0;
    bus_b.en = 1'b0; bus_b.req_valid = 4'b0000; bus_b.req_data = 32'h0;
    rst = 1'b0;
    repeat (3) tick();
    checks++; if (bus_a.tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", bus_a.tx); end
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus_a.busy); end
    checks++; if (bus_a.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b expected 0000", bus_a.req_ready); end
    checks++; if (bus_a.grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", bus_a.grant_id); end
    checks++; if (bus_a.frame_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus_a.frame_done); end
    checks++; if (bus_b.tx !== 1'b1) begin errors++; $display("FAIL reset_tx_b: got %b expected 1", bus_b.tx); end
    rst = 1'b1;
    repeat (2) tick();
    checks++; if (bus_a.tx !== 1'b1) begin errors++; $display("FAIL post_reset_tx: got %b expected 1", bus_a.tx); end
  endtask

  task automatic test_single_frame();
    logic [7:0] d;
    logic       exp_tx;
    int         bad;
    int         first_c;
    d = 8'hA5;
    bus_a.req_data  = 32'h0000_00A5;
    bus_a.req_valid = 4'b0001;
    bus_a.en        = 1'b1;
    tick();
    checks++; if (bus_a.req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b expected 0001", bus_a.req_ready); end
    checks++; if (bus_a.grant_id !== 2'd0) begin errors++; $display("FAIL single_grant: got %0d expected 0", bus_a.grant_id); end
    bus_a.req_valid = 4'b0000;
    bad = 0;
    first_c = -1;
    for (int c = 0; c < 80; c++) begin
      if (c > 0) tick();
      if (c < 8)       exp_tx = 1'b0;
      else if (c < 72) exp_tx = d[(c - 8) / 8];
      else             exp_tx = 1'b1;
      if (bus_a.tx !== exp_tx || bus_a.busy !== 1'b1 || bus_a.frame_done !== 1'b0 ||
          (c > 0 && bus_a.req_ready !== 4'b0000)) begin
        bad++;
        if (first_c < 0) begin
          first_c = c;
          $display("  cycle %0d: tx=%b exp %b busy=%b done=%b ready=%b", c, bus_a.tx, exp_tx,
                   bus_a.busy, bus_a.frame_done, bus_a.req_ready);
        end
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL single_waveform: got %0d bad cycles (first %0d) expected 0", bad, first_c); end
    tick();
    checks++; if (bus_a.frame_done !== 1'b1) begin errors++; $display("FAIL single_done_at_80: got %b expected 1", bus_a.frame_done); end
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", bus_a.busy); end
    tick();
    checks++; if (bus_a.frame_done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b expected 0", bus_a.frame_done); end
  endtask

  task automatic test_reset_midframe();
    int bad;
    bus_a.req_data  = 32'h0000_0000;
    bus_a.req_valid = 4'b0001;
    tick();
    checks++; if (bus_a.req_ready !== 4'b0001) begin errors++; $display("FAIL midrst_grant: got %b expected 0001", bus_a.req_ready); end
    bus_a.req_valid = 4'b0000;
    repeat (30) tick();
    checks++; if (bus_a.tx !== 1'b0) begin errors++; $display("FAIL midrst_pre_tx: got %b expected 0", bus_a.tx); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus_a.tx !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b expected 1", bus_a.tx); end
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", bus_a.busy); end
    checks++; if (bus_a.req_ready !== 4'b0000) begin errors++; $display("FAIL midrst_ready: got %b expected 0000", bus_a.req_ready); end
    tick();
    rst = 1'b1;
    bad = 0;
    repeat (20) begin
      tick();
      if (bus_a.tx !== 1'b1 || bus_a.req_ready !== 4'b0000 || bus_a.frame_done !== 1'b0 || bus_a.busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL midrst_idle_after: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic test_round_robin();
    logic [31:0] rr_data;
    logic [7:0]  rx;
    bit          found;
    int          n_cyc;
    int          exp_id;
    int          cur;
    rr_data         = 32'h4332_2110;
    bus_a.req_data  = rr_data;
    bus_a.req_valid = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      exp_id = f % 4;
      wait_ready_a(found);
      checks++; if (!found) begin errors++; $display("FAIL rr_timeout frame %0d: got no ready expected grant", f); end
      checks++; if (bus_a.req_ready !== (4'b0001 << exp_id)) begin errors++; $display("FAIL rr_ready frame %0d: got %b expected %b", f, bus_a.req_ready, 4'b0001 << exp_id); end
      checks++; if (bus_a.grant_id !== 2'(exp_id)) begin errors++; $display("FAIL rr_grant frame %0d: got %0d expected %0d", f, bus_a.grant_id, exp_id); end
      if (f == 4) bus_a.req_valid = 4'b0000;
      tick();
      cur = 1;
      checks++; if (bus_a.req_ready !== 4'b0000) begin errors++; $display("FAIL rr_pulse frame %0d: got %b expected 0000", f, bus_a.req_ready); end
      for (int k = 0; k < 8; k++) begin
        while (cur < 12 + 8 * k) begin tick(); cur++; end
        rx[k] = bus_a.tx;
      end
      checks++; if (rx !== rr_data[8 * exp_id +: 8]) begin errors++; $display("FAIL rr_byte frame %0d: got %h expected %h", f, rx, rr_data[8 * exp_id +: 8]); end
      wait_done_a(found, n_cyc);
      checks++; if (!found) begin errors++; $display("FAIL rr_done frame %0d: got no done expected pulse", f); end
    end
  endtask

  task automatic test_pointer_wrap();
    bit         found;
    int         n_cyc;
    logic [1:0] exp_ids [3];
    logic [3:0] next_v  [3];
    exp_ids = '{2'd3, 2'd0, 2'd3};
    next_v  = '{4'b1001, 4'b1000, 4'b0000};
    bus_a.req_valid = 4'b1000;
    for (int f = 0; f < 3; f++) begin
      wait_ready_a(found);
      checks++; if (!found) begin errors++; $display("FAIL wrap_timeout step %0d: got no ready expected grant", f); end
      checks++; if (bus_a.grant_id !== exp_ids[f]) begin errors++; $display("FAIL wrap_grant step %0d: got %0d expected %0d", f, bus_a.grant_id, exp_ids[f]); end
      bus_a.req_valid = next_v[f];
      wait_done_a(found, n_cyc);
    end
  endtask

  task automatic test_enable();
    int bad;
    bit found;
    int n_cyc;
    bus_a.en        = 1'b0;
    bus_a.req_valid = 4'b0100;
    bad = 0;
    repeat (100) begin
      tick();
      if (bus_a.req_ready !== 4'b0000 || bus_a.tx !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL en_gate: got %0d bad cycles expected 0", bad); end
    bus_a.en = 1'b1;
    tick();
    checks++; if (bus_a.req_ready !== 4'b0100) begin errors++; $display("FAIL en_ready: got %b expected 0100", bus_a.req_ready); end
    checks++; if (bus_a.grant_id !== 2'd2) begin errors++; $display("FAIL en_grant: got %0d expected 2", bus_a.grant_id); end
    bus_a.req_valid = 4'b0000;
    repeat (20) tick();
    bus_a.en = 1'b0;
    wait_done_a(found, n_cyc);
    checks++; if (!found || n_cyc != 60) begin errors++; $display("FAIL en_midframe_done: got found=%0d after %0d cycles expected 1 after 60", found, n_cyc); end
    bus_a.en = 1'b1;
  endtask

  task automatic test_two_stop();
    logic       tx_r    [46];
    logic       busy_r  [46];
    logic       done_r  [46];
    logic [3:0] ready_r [46];
    logic [7:0] rx;
    bit         found;
    int         bad;
    bus_b.en        = 1'b1;
    bus_b.req_data  = 32'h0000_C35A;
    bus_b.req_valid = 4'b0011;
    found = 1'b0;
    for (int n = 0; n < 50; n++) begin
      tick();
      if (bus_b.req_ready !== 4'b0000) begin found = 1'b1; break; end
    end
    checks++; if (!found || bus_b.req_ready !== 4'b0001) begin errors++; $display("FAIL two_stop_first: got %b expected 0001", bus_b.req_ready); end
    bus_b.req_valid = 4'b0010;
    for (int c = 0; c < 46; c++) begin
      if (c > 0) tick();
      tx_r[c] = bus_b.tx; busy_r[c] = bus_b.busy; done_r[c] = bus_b.frame_done; ready_r[c] = bus_b.req_ready;
    end
    for (int k = 0; k < 8; k++) rx[k] = tx_r[6 + 4 * k];
    checks++; if (rx !== 8'h5A) begin errors++; $display("FAIL two_stop_byte: got %h expected 5a", rx); end
    bad = 0;
    for (int c = 36; c < 45; c++) if (tx_r[c] !== 1'b1) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL two_stop_high: got %0d low cycles expected 0", bad); end
    checks++; if (busy_r[43] !== 1'b1 || busy_r[44] !== 1'b0) begin errors++; $display("FAIL two_stop_busy: got %b%b expected 10", busy_r[43], busy_r[44]); end
    checks++; if (done_r[43] !== 1'b0 || done_r[44] !== 1'b1) begin errors++; $display("FAIL two_stop_done: got %b%b expected 01", done_r[43], done_r[44]); end
    checks++; if (ready_r[45] !== 4'b0010 || tx_r[45] !== 1'b0) begin errors++; $display("FAIL two_stop_next: got ready=%b tx=%b expected 0010 0", ready_r[45], tx_r[45]); end
    checks++; if (bus_b.grant_id !== 2'd1) begin errors++; $display("FAIL two_stop_grant: got %0d expected 1", bus_b.grant_id); end
    bus_b.req_valid = 4'b0000;
    repeat (50) tick();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_reset_midframe();
    test_round_robin();
    test_pointer_wrap();
    test_enable();
    test_two_stop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one 8N1 UART transmit line among NUM_REQ byte sources using round-robin arbitration. Generates its own bit timing from a clock-cycle divisor, so its bit rate matches the team's 115200 bps baud timing (430 clocks/bit). It sits between the test-result producers and the board TX pin, one frame at a time.

Parameters:
CLKS_PER_BIT, 430, clock cycles per UART bit; legal range 2..65535.
NUM_REQ, 4, number of requesters; fixed at 4 (grant_id is 2 bits).
STOP_BITS, 1, stop bits per frame; legal values 1 or 2.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  asynchronous, active-low reset.
en  in  1  when low, no new grant is issued; a frame already in progress completes.
req_valid  in  4  bit i high = requester i has a byte pending.
req_data  in  32  byte for requester i at bits [8i+7:8i].
req_ready  out  4  one-cycle pulse: requester i's byte was accepted.
tx  out  1  serial line, idle high.
busy  out  1  high from the start bit through the last stop-bit cycle.
grant_id  out  2  index of the requester whose frame is on the line; holds its value when idle.
frame_done  out  1  one-cycle pulse after the last stop bit.

Behaviour:
- Reset (async, rst=0): tx=1, busy=0, req_ready=0, frame_done=0, grant_id=0, round-robin pointer=0, state=IDLE, counters=0. Asserting reset mid-frame aborts the frame immediately; no ready or done pulse follows.
- States: IDLE, START, DATA, STOP.
- IDLE: tx=1, busy=0. At a posedge with en=1 and |req_valid:
  - Winner = first i with req_valid[i]=1, searching from pointer upward and wrapping.
  - The shift register latches req_data[8*winner+:8].
  - grant_id<=winner; req_ready[winner]<=1 for exactly one cycle.
  - pointer<=(winner+1) mod 4; tx<=0; busy<=1; clock counter<=0; state<=START.
- Bit timing: the clock counter counts 0..CLKS_PER_BIT-1. Each bit occupies exactly CLKS_PER_BIT cycles of tx. The transition happens at the edge where counter==CLKS_PER_BIT-1; the counter then wraps to 0.
- START: after 1 bit time, tx<=data[0] and state<=DATA with bit index=0.
- DATA: bits go out LSB first. At the end of each bit, if the index is below 7, the index increments and tx takes the next bit. After bit 7, tx<=1 and state<=STOP.
- STOP: tx=1 for STOP_BITS bit times. At the final edge: state<=IDLE, busy<=0, frame_done<=1 for one cycle.
- Frame length: tx low from edge E; the line returns to idle exactly (9+STOP_BITS)*CLKS_PER_BIT cycles after E. A new grant is possible in the first IDLE cycle, so the minimum inter-frame gap is 1 clock of tx=1 beyond the stop bits.
- Handshake:
  - A requester holds valid and data stable until it sees ready.
  - Dropping valid before being granted is legal and has no effect.
  - req_valid and req_data are ignored outside IDLE.
  - At most one req_ready bit is ever high at a time.
- en=0 in IDLE: no grant, pointer unchanged. en falling mid-frame does not affect the frame.
- Simultaneous requests: only the winner is served. The others stay pending and are served in rotation order, so no requester waits more than 3 frames while it keeps valid high.

Test Plan:
- Reset: rst=0 mid-DATA of a frame with CLKS_PER_BIT=8 -> tx=1, busy=0, req_ready=0 asynchronously; after release with no requests, tx stays 1.
- Single frame: CLKS_PER_BIT=8, STOP_BITS=1, req_valid=4'b0001, data 0xA5 -> one req_ready[0] pulse coincident with tx falling. tx then shows start 0 followed by 1,0,1,0,0,1,0,1, each bit held 8 cycles, then stop 1. frame_done pulses 80 cycles after tx falls; busy is high for 80 cycles.
- Round-robin: all four valid permanently, data 0x10/0x21/0x32/0x43 -> grants in order 0,1,2,3,0; bytes on tx match; each req_ready pulse is a single cycle.
- Pointer wrap: grant 3, then only requesters 0 and 3 valid -> next grant is 0, then 3.
- Enable gating: en=0 with req_valid=4'b0100 -> no ready and tx=1 for 100 cycles. en=1 -> grant to 2 on the next edge. Dropping en mid-frame still completes the frame.
- STOP_BITS=2, CLKS_PER_BIT=4: back-to-back frames -> stop high for 8 cycles plus a 1-cycle idle gap before the next start bit.
